// File: rtl/general_register_file_if.sv
// Decode/execute-side bundle for the general register file: per-port read requests with
// registered results, plus a single merging write port.
interface general_register_file_if #(
  parameter int unsigned READ_PORTS = 2
);
  logic [READ_PORTS-1:0]    rd_en;
  logic [3*READ_PORTS-1:0]  rd_code;
  logic [READ_PORTS-1:0]    rd_w;
  logic [READ_PORTS-1:0]    rd_size32;
  logic [32*READ_PORTS-1:0] rd_data;
  logic [READ_PORTS-1:0]    rd_valid;

  logic        wr_en;
  logic [2:0]  wr_code;
  logic        wr_w;
  logic        wr_size32;
  logic [31:0] wr_data;

  modport master (
    output rd_en, rd_code, rd_w, rd_size32,
    output wr_en, wr_code, wr_w, wr_size32, wr_data,
    input  rd_data, rd_valid
  );

  modport slave (
    input  rd_en, rd_code, rd_w, rd_size32,
    input  wr_en, wr_code, wr_w, wr_size32, wr_data,
    output rd_data, rd_valid
  );
endinterface

// File: rtl/general_register_file.sv
// Eight 32-bit x86 general registers (EAX..EDI) with byte/word/dword sub-register access,
// READ_PORTS registered read ports, one merging write port and optional write-to-read bypass.
module general_register_file #(
  parameter int unsigned READ_PORTS = 2,
  parameter bit          BYPASS     = 1'b1,
  parameter logic [31:0] RESET_ESP  = 32'h0000_0000
) (
  input logic clock,
  input logic reset,
  general_register_file_if.slave bus
);

  logic [31:0]           regs_q    [8];
  logic [31:0]           regs_d    [8];
  logic [31:0]           rd_data_q [READ_PORTS];
  logic [31:0]           rd_data_d [READ_PORTS];
  logic [READ_PORTS-1:0] rd_valid_q;

  // Byte codes 4..7 (AH..BH) alias the second byte of registers 0..3.
  function automatic logic [2:0] phys_idx(input logic [2:0] code, input logic w);
    return w ? code : {1'b0, code[1:0]};
  endfunction

  function automatic logic [31:0] merge_field(input logic [31:0] old_val,
                                              input logic [2:0]  code,
                                              input logic        w,
                                              input logic        size32,
                                              input logic [31:0] data);
    logic [31:0] res;
    res = old_val;
    if (!w) begin
      if (code[2]) res[15:8] = data[7:0];
      else         res[7:0]  = data[7:0];
    end else if (size32) begin
      res = data;
    end else begin
      res[15:0] = data[15:0];
    end
    return res;
  endfunction

  function automatic logic [31:0] extract_field(input logic [31:0] val,
                                                input logic [2:0]  code,
                                                input logic        w,
                                                input logic        size32);
    logic [31:0] res;
    if (!w) begin
      res = code[2] ? {24'h0, val[15:8]} : {24'h0, val[7:0]};
    end else if (size32) begin
      res = val;
    end else begin
      res = {16'h0, val[15:0]};
    end
    return res;
  endfunction

  // Next register contents; only the write target can differ from regs_q.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (bus.wr_en) begin
      regs_d[phys_idx(bus.wr_code, bus.wr_w)] =
          merge_field(regs_q[phys_idx(bus.wr_code, bus.wr_w)], bus.wr_code, bus.wr_w,
                      bus.wr_size32, bus.wr_data);
    end
  end

  // Bypass reads from regs_d, so overlap is resolved on the physical register, not the field.
  always_comb begin
    for (int p = 0; p < READ_PORTS; p++) begin
      rd_data_d[p] = rd_data_q[p];
      if (bus.rd_en[p]) begin
        if (BYPASS) begin
          rd_data_d[p] = extract_field(regs_d[phys_idx(bus.rd_code[3*p +: 3], bus.rd_w[p])],
                                       bus.rd_code[3*p +: 3], bus.rd_w[p], bus.rd_size32[p]);
        end else begin
          rd_data_d[p] = extract_field(regs_q[phys_idx(bus.rd_code[3*p +: 3], bus.rd_w[p])],
                                       bus.rd_code[3*p +: 3], bus.rd_w[p], bus.rd_size32[p]);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= (i == 4) ? RESET_ESP : 32'h0;
      end
      for (int p = 0; p < READ_PORTS; p++) begin
        rd_data_q[p] <= 32'h0;
      end
      rd_valid_q <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= regs_d[i];
      end
      for (int p = 0; p < READ_PORTS; p++) begin
        rd_data_q[p] <= rd_data_d[p];
      end
      rd_valid_q <= bus.rd_en;
    end
  end

  always_comb begin
    bus.rd_data = '0;
    for (int p = 0; p < READ_PORTS; p++) begin
      bus.rd_data[32*p +: 32] = rd_data_q[p];
    end
  end

  assign bus.rd_valid = rd_valid_q;

endmodule

// File: tb/tb_general_register_file.sv
// Directed bench for general_register_file: a bypassing and a non-bypassing instance share
// the same stimulus and are checked against hand-computed tables.
module tb_general_register_file;

  localparam logic [31:0] ESP_RST    = 32'hDEAD_7FF0;
  localparam logic [31:0] ESP_RST_LO = 32'h0000_7FF0;
  localparam int          NVEC       = 18;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  general_register_file_if #(.READ_PORTS(2)) bus ();
  general_register_file_if #(.READ_PORTS(2)) bus_nb ();

  assign bus_nb.rd_en     = bus.rd_en;
  assign bus_nb.rd_code   = bus.rd_code;
  assign bus_nb.rd_w      = bus.rd_w;
  assign bus_nb.rd_size32 = bus.rd_size32;
  assign bus_nb.wr_en     = bus.wr_en;
  assign bus_nb.wr_code   = bus.wr_code;
  assign bus_nb.wr_w      = bus.wr_w;
  assign bus_nb.wr_size32 = bus.wr_size32;
  assign bus_nb.wr_data   = bus.wr_data;

  general_register_file #(.READ_PORTS(2), .BYPASS(1'b1), .RESET_ESP(ESP_RST)) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  general_register_file #(.READ_PORTS(2), .BYPASS(1'b0), .RESET_ESP(ESP_RST)) u_dut_nb (
    .clock (clock),
    .reset (reset),
    .bus   (bus_nb)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [1:0]  en;
    logic [5:0]  code;
    logic [1:0]  w;
    logic [1:0]  s;
    logic        we;
    logic [2:0]  wc;
    logic        ww;
    logic        ws;
    logic [31:0] wd;
    logic [1:0]  ev;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [31:0] nb0;
    logic [31:0] nb1;
  } vec_t;

  vec_t vecs [NVEC];

  function automatic vec_t mk(string nm, logic [1:0] en,
                              logic [2:0] c0, logic w0, logic s0,
                              logic [2:0] c1, logic w1, logic s1,
                              logic we, logic [2:0] wc, logic ww, logic ws, logic [31:0] wd,
                              logic [1:0] ev, logic [31:0] e0, logic [31:0] e1);
    vec_t v;
    v.name = nm;  v.en = en;  v.code = {c1, c0};  v.w = {w1, w0};  v.s = {s1, s0};
    v.we = we;  v.wc = wc;  v.ww = ww;  v.ws = ws;  v.wd = wd;
    v.ev = ev;  v.e0 = e0;  v.e1 = e1;  v.nb0 = e0;  v.nb1 = e1;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] en, input logic [5:0] code, input logic [1:0] w,
                       input logic [1:0] s, input logic we, input logic [2:0] wc,
                       input logic ww, input logic ws, input logic [31:0] wd);
    bus.rd_en = en;  bus.rd_code = code;  bus.rd_w = w;  bus.rd_size32 = s;
    bus.wr_en = we;  bus.wr_code = wc;  bus.wr_w = ww;  bus.wr_size32 = ws;  bus.wr_data = wd;
  endtask

  task automatic check_all(input string name, input logic [1:0] ev, input logic [31:0] e0,
                           input logic [31:0] e1, input logic [31:0] n0, input logic [31:0] n1);
    check({name, ".valid"},    {30'h0, bus.rd_valid},    {30'h0, ev});
    check({name, ".data0"},    bus.rd_data[31:0],        e0);
    check({name, ".data1"},    bus.rd_data[63:32],       e1);
    check({name, ".nb_valid"}, {30'h0, bus_nb.rd_valid}, {30'h0, ev});
    check({name, ".nb_data0"}, bus_nb.rd_data[31:0],     n0);
    check({name, ".nb_data1"}, bus_nb.rd_data[63:32],    n1);
  endtask

  logic [2:0]  code;
  logic        w;
  logic        s;
  logic [31:0] exp;

  initial begin
    checks = 0;
    errors = 0;

    vecs[0]  = mk("wr_eax", 2'b00, 0,0,0, 0,0,0, 1, 0,1,1, 32'h1234_5678, 2'b00, 0, 0);
    vecs[1]  = mk("wr_ah", 2'b00, 0,0,0, 0,0,0, 1, 4,0,0, 32'h0000_00AB, 2'b00, 0, 0);
    vecs[2]  = mk("rd_eax_al", 2'b11, 0,1,1, 0,0,0, 0, 0,0,0, 0, 2'b11,
                  32'h1234_AB78, 32'h0000_0078);
    vecs[3]  = mk("rd_ah_ax", 2'b11, 4,0,0, 0,1,0, 0, 0,0,0, 0, 2'b11,
                  32'h0000_00AB, 32'h0000_AB78);
    vecs[4]  = mk("wr_edi", 2'b00, 0,0,0, 0,0,0, 1, 7,1,1, 32'hFFFF_FFFF, 2'b00,
                  32'h0000_00AB, 32'h0000_AB78);
    vecs[5]  = mk("wr_di", 2'b00, 0,0,0, 0,0,0, 1, 7,1,0, 32'h1234_BEEF, 2'b00,
                  32'h0000_00AB, 32'h0000_AB78);
    vecs[6]  = mk("wr_bh_rd_edi", 2'b01, 7,1,1, 0,0,0, 1, 7,0,0, 32'hFFFF_FF11, 2'b01,
                  32'hFFFF_BEEF, 32'h0000_AB78);
    vecs[7]  = mk("rd_ebx_bl", 2'b11, 3,1,1, 3,0,0, 0, 0,0,0, 0, 2'b11,
                  32'h0000_1100, 32'h0000_0000);
    vecs[8]  = mk("wr_ecx", 2'b00, 0,0,0, 0,0,0, 1, 1,1,1, 32'h0000_2200, 2'b00,
                  32'h0000_1100, 32'h0000_0000);
    vecs[9]  = mk("byp_ch", 2'b11, 1,1,1, 5,0,0, 1, 1,1,1, 32'hCAFE_0001, 2'b11,
                  32'hCAFE_0001, 32'h0000_0000);
    vecs[9].nb0 = 32'h0000_2200;
    vecs[9].nb1 = 32'h0000_0022;
    vecs[10] = mk("rd_ecx_wr_edx", 2'b11, 1,1,1, 1,0,0, 1, 2,1,1, 32'hA5A5_1234, 2'b11,
                  32'hCAFE_0001, 32'h0000_0001);
    vecs[11] = mk("rd_edx_x2", 2'b11, 2,1,1, 2,1,1, 0, 0,0,0, 0, 2'b11,
                  32'hA5A5_1234, 32'hA5A5_1234);
    vecs[12] = mk("wr_dl_rd_dh", 2'b01, 6,0,0, 0,0,0, 1, 2,0,0, 32'h0000_0077, 2'b01,
                  32'h0000_0012, 32'hA5A5_1234);
    vecs[13] = mk("rd_edx", 2'b01, 2,1,1, 0,0,0, 0, 0,0,0, 0, 2'b01,
                  32'hA5A5_1277, 32'hA5A5_1234);
    vecs[14] = mk("idle", 2'b00, 2,1,1, 2,1,1, 0, 0,0,0, 0, 2'b00,
                  32'hA5A5_1277, 32'hA5A5_1234);
    vecs[15] = mk("wr_sp", 2'b00, 0,0,0, 0,0,0, 1, 4,1,0, 32'hFFFF_1111, 2'b00,
                  32'hA5A5_1277, 32'hA5A5_1234);
    vecs[16] = mk("rd_esp_sp", 2'b11, 4,1,1, 4,1,0, 0, 0,0,0, 0, 2'b11,
                  32'hDEAD_1111, 32'h0000_1111);
    vecs[17] = mk("wr_al_byp_eax", 2'b01, 0,1,1, 0,0,0, 1, 0,0,0, 32'hFFFF_FFCD, 2'b01,
                  32'h1234_ABCD, 32'h0000_1111);
    vecs[17].nb0 = 32'h1234_AB78;

    // Reset with a write and reads requested; both must be ignored.
    reset = 1'b1;
    drive(2'b11, 6'o00, 2'b11, 2'b11, 1'b1, 3'd0, 1'b1, 1'b1, 32'hFFFF_FFFF);
    repeat (3) @(negedge clock);
    check_all("reset", 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    reset = 1'b0;
    drive(2'b00, 6'o00, 2'b00, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0);

    // Every code under byte, word and dword decode.
    for (int c = 0; c < 8; c++) begin
      for (int k = 0; k < 3; k++) begin
        code = 3'(c);
        w    = (k != 0);
        s    = (k == 2) || ((k == 0) && code[0]);
        exp  = 32'h0;
        if (w && code == 3'd4) exp = s ? ESP_RST : ESP_RST_LO;
        drive(2'b01, {3'd0, code}, {1'b0, w}, {1'b0, s}, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0);
        @(negedge clock);
        check_all($sformatf("scan_c%0d_k%0d", c, k), 2'b01, exp, 32'h0, exp, 32'h0);
        drive(2'b00, {3'd0, code}, {1'b0, w}, {1'b0, s}, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0);
        @(negedge clock);
        check_all($sformatf("scan_idle_c%0d_k%0d", c, k), 2'b00, exp, 32'h0, exp, 32'h0);
      end
    end

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].en, vecs[i].code, vecs[i].w, vecs[i].s, vecs[i].we, vecs[i].wc,
            vecs[i].ww, vecs[i].ws, vecs[i].wd);
      @(negedge clock);
      check_all(vecs[i].name, vecs[i].ev, vecs[i].e0, vecs[i].e1, vecs[i].nb0, vecs[i].nb1);
    end

    // Reset in the cycle after a read, with a write pending.
    drive(2'b11, {3'd2, 3'd0}, 2'b11, 2'b11, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0);
    @(negedge clock);
    check_all("pre_rst_rd", 2'b11, 32'h1234_ABCD, 32'hA5A5_1277, 32'h1234_ABCD, 32'hA5A5_1277);
    reset = 1'b1;
    drive(2'b11, {3'd2, 3'd0}, 2'b11, 2'b11, 1'b1, 3'd2, 1'b1, 1'b1, 32'hFFFF_FFFF);
    @(negedge clock);
    check_all("mid_rst", 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    reset = 1'b0;
    drive(2'b00, 6'o00, 2'b00, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0);
    @(negedge clock);
    check_all("post_rst_idle", 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    drive(2'b11, {3'd4, 3'd2}, 2'b11, 2'b11, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0);
    @(negedge clock);
    check_all("post_rst_edx_esp", 2'b11, 32'h0, ESP_RST, 32'h0, ESP_RST);
    drive(2'b11, {3'd1, 3'd0}, 2'b11, 2'b11, 1'b0, 3'd0, 1'b0, 1'b0, 32'h0);
    @(negedge clock);
    check_all("post_rst_eax_ecx", 2'b11, 32'h0, 32'h0, 32'h0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/general_register_file.md
Name: general_register_file

Overview:
- Architectural general-purpose register file for the w80386dx integer core: eight 32-bit registers, EAX..EDI.
- Reads and writes use the x86 3-bit register code qualified by the instruction w bit and the effective operand size, so the same decode as the general-register decoder is applied per port.
- Provides READ_PORTS registered read ports and one write port with byte, word and dword sub-register merging.
- Optional write-to-read bypass.
- Sits between the decode stage and the execute stage.

Parameters:
- READ_PORTS, 2, number of independent read ports (1..4).
- BYPASS, 1, 1: a same-cycle write is forwarded to reads; 0: reads return the pre-write contents.
- RESET_ESP, 32'h0000_0000, reset value of register 4 (ESP); all other registers reset to 0.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- rd_en  in  READ_PORTS  per-port read request.
- rd_code  in  3*READ_PORTS  per-port register code; port p uses bits [3p+2:3p].
- rd_w  in  READ_PORTS  per-port w bit; 0 selects byte access.
- rd_size32  in  READ_PORTS  per-port operand size when w=1; 1 selects 32-bit, 0 selects 16-bit.
- rd_data  out  32*READ_PORTS  per-port read data, zero-extended.
- rd_valid  out  READ_PORTS  per-port qualifier for rd_data.
- wr_en  in  1  write request.
- wr_code  in  3  write register code.
- wr_w  in  1  write w bit.
- wr_size32  in  1  write operand size.
- wr_data  in  32  write data; only the low 8, 16 or 32 bits are used.

Behaviour:
- Clock port is named clock; reset is synchronous, active-high and named reset.
- Decode, identical for read and write ports:
  - w=0, code 0..3 -> AL,CL,DL,BL: bits [7:0] of register code.
  - w=0, code 4..7 -> AH,CH,DH,BH: bits [15:8] of register (code-4).
  - w=1, size32=0 -> AX..DI: bits [15:0] of register code.
  - w=1, size32=1 -> EAX..EDI: bits [31:0] of register code.
  - size32 is ignored when w=0.
- Write:
  - On a rising edge with wr_en=1 and reset=0, only the selected field of the target register is replaced with the low bits of wr_data.
  - All other bits of that register, and all other registers, hold.
- Read:
  - Latency is 1 cycle: rd_en sampled at edge N -> rd_data and rd_valid presented after edge N, held until the next edge.
  - rd_valid[p] <= rd_en[p] every cycle.
  - When rd_en[p]=0: rd_data[p] holds its previous value and rd_valid[p]=0.
  - Byte reads return {24'b0, byte}; word reads return {16'b0, word}.
  - AH-class reads are shifted down to bits [7:0].
- Bypass:
  - Applies when BYPASS=1, wr_en=1 and a read in the same cycle targets the same physical register.
  - The read returns the field extracted from the merged post-write register value; overlap is checked on the physical register, not the field.
  - With BYPASS=0 the read returns the pre-write value.
- Multiple read ports may read the same register in the same cycle, and each gets an independent result.
- Reset:
  - Every register is 0 except register 4, which takes RESET_ESP.
  - All rd_data=0, all rd_valid=0.
  - A wr_en or rd_en asserted in a reset cycle is ignored.
  - Reset asserted mid-stream drops any read in flight: rd_valid=0 on the cycle after.
- No X propagation: all codes 0..7 decode for every w/size combination; no illegal encodings exist.

Test Plan:
1. Reset, then read all 24 code/w/size32 combinations on port 0 -> rd_data=0 (ESP field = RESET_ESP); rd_valid high exactly one cycle after each rd_en.
2. Write EAX=32'h1234_5678 (code 0, w=1, size32=1), then byte write AH=8'hAB (code 4, w=0):
   - read EAX -> 32'h1234_AB78.
   - read AL -> 32'h0000_0078.
   - read AH -> 32'h0000_00AB.
   - read AX (size32=0) -> 32'h0000_AB78.
3. Word write DI=16'hBEEF (code 7, w=1, size32=0) over EDI=32'hFFFF_FFFF -> EDI reads 32'hFFFF_BEEF; BH (code 7, w=0) write 8'h11 targets EBX bits [15:8], and EDI is unchanged.
4. BYPASS=1: write ECX=32'hCAFE_0001 while port 1 reads CH in the same cycle -> rd_data[1]=32'h0000_0000 next cycle. With BYPASS=0 and ECX previously 32'h0000_2200 -> 32'h0000_0022.
5. Both ports read EDX in the same cycle -> identical values. Port 0 rd_en, port 1 idle -> rd_valid=2'b01 and rd_data[1] unchanged.
6. Assert reset in the cycle after a rd_en, with a write pending -> rd_valid=0, rd_data=0, target register = 0 (register 4 = RESET_ESP).
